// File: rtl/riscv_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : riscv_fetch_unit
// Description : Instruction fetch unit. It holds the program counter and the
//               instruction register, and runs a single-outstanding
//               request/acknowledge handshake to instruction memory with a
//               timeout.
//   Ports:
//     clk, reset          - clock, synchronous active-high reset
//     pc_reset, pc_load   - PC reload / PC update requests (control unit)
//     pc_sel[1:0]         - next-PC source: 00 pc+4, 01 pc+imm, 10 imm, 11 hold
//     branch_imm[31:0]    - branch offset or absolute target
//     fetch_start         - one-cycle fetch request
//     imem_ack, imem_rdata- memory response
//     imem_req, imem_addr - memory request
//     pc, instr, opcode   - program counter, instruction register, instr[6:0]
//     fetch_done, busy    - completion pulse, fetch outstanding
//     fetch_err           - sticky error (timeout or misaligned target)
// Revision    : 1.0 - initial release
// ============================================================================
module riscv_fetch_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'h00000000,
    parameter int          TIMEOUT      = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pc_reset,
    input  logic        pc_load,
    input  logic [1:0]  pc_sel,
    input  logic [31:0] branch_imm,
    input  logic        fetch_start,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    output logic [31:0] pc,
    output logic [31:0] instr,
    output logic [6:0]  opcode,
    output logic        fetch_done,
    output logic        busy,
    output logic        fetch_err
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    localparam logic [31:0] c_nop = 32'h00000013;

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [31:0]      w_next_pc;
    logic             w_cnt_last;
    logic             w_pc_window;

    // Next-PC selection; modulo-2^32 arithmetic falls out of the 32-bit add.
    always_comb begin
        w_next_pc = pc;
        case (pc_sel)
            2'b00:   w_next_pc = pc + 32'd4;
            2'b01:   w_next_pc = pc + branch_imm;
            2'b10:   w_next_pc = branch_imm;
            default: w_next_pc = pc;
        endcase
    end

    assign w_cnt_last  = (r_cnt == CNT_W'(TIMEOUT - 1));
    // PC may only move while no memory request is outstanding, so the
    // address presented to memory stays stable for the whole request.
    assign w_pc_window = (r_state != ST_REQ);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            pc        <= RESET_VECTOR;
            instr     <= c_nop;
            fetch_err <= 1'b0;
        end else begin
            // PC update; a fetch started in the same IDLE cycle picks up
            // the new PC because the request is issued from the next cycle.
            if (w_pc_window) begin
                if (pc_reset) begin
                    pc        <= RESET_VECTOR;
                    fetch_err <= 1'b0;
                end else if (pc_load) begin
                    if (w_next_pc[1:0] != 2'b00) begin
                        fetch_err <= 1'b1;
                    end else begin
                        pc <= w_next_pc;
                    end
                end
            end

            case (r_state)
                ST_IDLE: begin
                    if (fetch_start) begin
                        r_state <= ST_REQ;
                        r_cnt   <= '0;
                    end
                end
                ST_REQ: begin
                    // Acknowledge wins over a timeout in the same cycle.
                    if (imem_ack) begin
                        instr   <= imem_rdata;
                        r_state <= ST_DONE;
                    end else if (w_cnt_last) begin
                        fetch_err <= 1'b1;
                        r_state   <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign imem_req   = (r_state == ST_REQ);
    assign busy       = (r_state == ST_REQ);
    assign fetch_done = (r_state == ST_DONE);
    assign imem_addr  = pc;
    assign opcode     = instr[6:0];

endmodule
`default_nettype wire

// File: tb/tb_riscv_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_riscv_fetch_unit
// Description : Directed self-checking bench for riscv_fetch_unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_riscv_fetch_unit;

    logic        clk;
    logic        reset;
    logic        pc_reset;
    logic        pc_load;
    logic [1:0]  pc_sel;
    logic [31:0] branch_imm;
    logic        fetch_start;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [6:0]  opcode;
    logic        fetch_done;
    logic        busy;
    logic        fetch_err;

    int r_tests;
    int r_fails;

    riscv_fetch_unit #(
        .RESET_VECTOR(32'h00000000),
        .TIMEOUT     (16)
    ) u_dut (
        .clk        (clk),
        .reset      (reset),
        .pc_reset   (pc_reset),
        .pc_load    (pc_load),
        .pc_sel     (pc_sel),
        .branch_imm (branch_imm),
        .fetch_start(fetch_start),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .pc         (pc),
        .instr      (instr),
        .opcode     (opcode),
        .fetch_done (fetch_done),
        .busy       (busy),
        .fetch_err  (fetch_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        r_tests++;
        if (act !== exp) begin
            r_fails++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Advance one rising edge; inputs are driven and outputs sampled 1 ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_pc(input logic [1:0] sel, input logic [31:0] imm);
        pc_load    = 1'b1;
        pc_sel     = sel;
        branch_imm = imm;
        tick();
        pc_load    = 1'b0;
    endtask

    initial begin
        int n;
        int dones;
        r_tests     = 0;
        r_fails     = 0;
        reset       = 1'b1;
        pc_reset    = 1'b0;
        pc_load     = 1'b0;
        pc_sel      = 2'b00;
        branch_imm  = 32'h0;
        fetch_start = 1'b0;
        imem_ack    = 1'b0;
        imem_rdata  = 32'h0;
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        check_val("rst_pc",    pc,                 32'h00000000);
        check_val("rst_instr", instr,              32'h00000013);
        check_val("rst_op",    {25'd0, opcode},    32'h00000013);
        check_val("rst_req",   {31'd0, imem_req},  32'd0);
        check_val("rst_busy",  {31'd0, busy},      32'd0);
        check_val("rst_done",  {31'd0, fetch_done},32'd0);
        check_val("rst_err",   {31'd0, fetch_err}, 32'd0);

        // Fetch with ack three cycles after fetch_start
        fetch_start = 1'b1;
        tick();                                   // cycle 1
        fetch_start = 1'b0;
        check_val("f1_req",  {31'd0, imem_req}, 32'd1);
        check_val("f1_busy", {31'd0, busy},     32'd1);
        check_val("f1_addr", imem_addr,         32'h00000000);
        tick();                                   // cycle 2
        check_val("f1_req2", {31'd0, imem_req}, 32'd1);
        tick();                                   // cycle 3
        imem_ack   = 1'b1;
        imem_rdata = 32'h00500093;
        check_val("f1_nodone", {31'd0, fetch_done}, 32'd0);
        tick();                                   // cycle 4
        imem_ack = 1'b0;
        check_val("f1_done",  {31'd0, fetch_done}, 32'd1);
        check_val("f1_instr", instr,               32'h00500093);
        check_val("f1_op",    {25'd0, opcode},     32'h00000013);
        check_val("f1_reqlo", {31'd0, imem_req},   32'd0);
        tick();
        check_val("f1_pulse", {31'd0, fetch_done}, 32'd0);

        // Ack while idle is ignored
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEADBEEF;
        tick();
        imem_ack = 1'b0;
        tick();
        check_val("idle_ack_instr", instr,               32'h00500093);
        check_val("idle_ack_done",  {31'd0, fetch_done}, 32'd0);

        // PC arithmetic
        load_pc(2'b00, 32'h0);
        check_val("pc_p4a", pc, 32'h00000004);
        load_pc(2'b00, 32'h0);
        check_val("pc_p4b", pc, 32'h00000008);
        load_pc(2'b01, 32'hFFFFFFF8);
        check_val("pc_rel_neg", pc, 32'h00000000);
        load_pc(2'b10, 32'hFFFFFFFC);
        check_val("pc_abs", pc, 32'hFFFFFFFC);
        load_pc(2'b00, 32'h0);
        check_val("pc_wrap", pc, 32'h00000000);
        load_pc(2'b10, 32'h00000020);
        load_pc(2'b11, 32'h00000040);
        check_val("pc_hold", pc, 32'h00000020);
        check_val("pc_noerr", {31'd0, fetch_err}, 32'd0);

        // Timeout with a pc_load attempted during REQ
        fetch_start = 1'b1;
        tick();
        fetch_start = 1'b0;
        pc_load     = 1'b1;
        pc_sel      = 2'b10;
        branch_imm  = 32'h00000040;
        n     = 0;
        dones = 0;
        while (imem_req && n < 40) begin
            n++;
            tick();
            pc_load = 1'b0;
            if (fetch_done) dones++;
        end
        check_val("to_cycles", n,                   32'd16);
        check_val("to_err",    {31'd0, fetch_err},  32'd1);
        check_val("to_instr",  instr,               32'h00500093);
        check_val("to_nodone", dones,               32'd0);
        check_val("req_pcload", pc,                 32'h00000020);

        // pc_reset with pc_load together: reset wins, error cleared
        pc_reset   = 1'b1;
        pc_load    = 1'b1;
        pc_sel     = 2'b00;
        tick();
        pc_reset = 1'b0;
        pc_load  = 1'b0;
        check_val("pcr_pc",  pc,                  32'h00000000);
        check_val("pcr_err", {31'd0, fetch_err},  32'd0);

        // Misaligned absolute target
        load_pc(2'b10, 32'h00000020);
        load_pc(2'b10, 32'h00000102);
        check_val("mis_pc",  pc,                 32'h00000020);
        check_val("mis_err", {31'd0, fetch_err}, 32'd1);
        pc_reset = 1'b1;
        tick();
        pc_reset = 1'b0;
        check_val("mis_clr", {31'd0, fetch_err}, 32'd0);

        // pc_load + fetch_start together, zero-wait ack
        pc_load     = 1'b1;
        pc_sel      = 2'b10;
        branch_imm  = 32'h00000080;
        fetch_start = 1'b1;
        tick();                                   // cycle 1
        pc_load     = 1'b0;
        fetch_start = 1'b0;
        check_val("zw_addr", imem_addr,         32'h00000080);
        check_val("zw_req",  {31'd0, imem_req}, 32'd1);
        imem_ack   = 1'b1;
        imem_rdata = 32'h00A00113;
        tick();                                   // cycle 2
        imem_ack    = 1'b0;
        fetch_start = 1'b1;                       // ignored in DONE
        check_val("zw_done",  {31'd0, fetch_done}, 32'd1);
        check_val("zw_instr", instr,               32'h00A00113);
        tick();
        fetch_start = 1'b0;
        check_val("done_fs_ign", {31'd0, imem_req}, 32'd0);

        // Reset mid-REQ, ack afterwards is ignored
        fetch_start = 1'b1;
        tick();
        fetch_start = 1'b0;
        check_val("mr_req", {31'd0, imem_req}, 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_val("mr_reqlo", {31'd0, imem_req}, 32'd0);
        imem_ack   = 1'b1;
        imem_rdata = 32'h12345678;
        tick();
        imem_ack = 1'b0;
        check_val("mr_nodone", {31'd0, fetch_done}, 32'd0);
        check_val("mr_instr",  instr,               32'h00000013);
        check_val("mr_busy",   {31'd0, busy},       32'd0);

        $display("[TB] %0d tests run, %0d failed", r_tests, r_fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/riscv_fetch_unit.md
RISCV_FETCH_UNIT -- requirements
Module: riscv_fetch_unit

Interface
REQ-001 Parameter RESET_VECTOR, default 32'h00000000, SHALL be the PC value loaded by reset or pc_reset.
REQ-002 Parameter TIMEOUT, default 16, SHALL be the maximum number of cycles imem_req stays high without imem_ack.
REQ-003 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 reset  input  1  SHALL be a synchronous, active-high reset.
REQ-005 pc_reset  input  1  SHALL request PC reload to RESET_VECTOR (from control unit).
REQ-006 pc_load  input  1  SHALL request a PC update selected by pc_sel (from control unit).
REQ-007 pc_sel  input  2  SHALL select the next-PC source: 00 pc+4, 01 pc+branch_imm, 10 branch_imm absolute, 11 hold.
REQ-008 branch_imm  input  32  SHALL be the offset or target used by pc_sel 01/10.
REQ-009 fetch_start  input  1  SHALL be a one-cycle request to fetch the instruction at pc.
REQ-010 imem_ack  input  1  SHALL mark imem_rdata valid for the outstanding request.
REQ-011 imem_rdata  input  32  SHALL be the instruction word from instruction memory.
REQ-012 imem_req  output  1  SHALL request an instruction memory read.
REQ-013 imem_addr  output  32  SHALL carry the fetch address; equal to pc.
REQ-014 pc  output  32  SHALL be the current program counter.
REQ-015 instr  output  32  SHALL be the instruction register.
REQ-016 opcode  output  7  SHALL equal instr[6:0] combinationally; feeds the control unit.
REQ-017 fetch_done  output  1  SHALL be a one-cycle pulse when instr is newly updated.
REQ-018 busy  output  1  SHALL be high while a fetch is outstanding.
REQ-019 fetch_err  output  1  SHALL be a sticky error flag (timeout or misaligned PC target).

Function
REQ-020 FSM states SHALL be IDLE, REQ, DONE; busy = (state == REQ).
REQ-021 IDLE: fetch_start=1 -> REQ next cycle, with imem_req=1 and timeout counter cleared to 0.
REQ-022 REQ: imem_req SHALL stay 1 and imem_addr stable until imem_ack or timeout.
REQ-023 REQ with imem_ack=1: instr <= imem_rdata, imem_req drops next cycle, state -> DONE.
REQ-024 DONE: fetch_done=1 for exactly that cycle; -> IDLE unconditionally.
REQ-025 Latency: fetch_start at cycle 0, imem_req from cycle 1; ack at cycle k (k>=1) -> fetch_done at cycle k+1; zero-wait ack (k=1) gives fetch_done at cycle 2.
REQ-026 REQ counter SHALL increment each cycle without ack; reaching TIMEOUT-1 without ack -> fetch_err=1, state -> IDLE, instr unchanged, no fetch_done.
REQ-027 imem_ack outside REQ SHALL be ignored; fetch_start outside IDLE SHALL be ignored.
REQ-028 PC update SHALL occur only in IDLE or DONE; pc_load/pc_reset during REQ SHALL be ignored.
REQ-029 pc_reset SHALL have priority over pc_load; pc_reset sets pc=RESET_VECTOR and clears fetch_err.
REQ-030 PC arithmetic SHALL be 32-bit modulo 2^32 (wrap-around; 32'hFFFFFFFC+4 = 0); branch_imm is two's complement.
REQ-031 A computed next-PC with bits[1:0] != 00 SHALL leave pc unchanged and set fetch_err.
REQ-032 pc_load and fetch_start in the same IDLE cycle: pc updates and the fetch uses the updated pc.

Reset
REQ-033 On reset: state IDLE, pc=RESET_VECTOR, instr=32'h00000013 (NOP, opcode 0010011), imem_req=0, fetch_done=0, busy=0, fetch_err=0, counter=0.
REQ-034 Reset during REQ SHALL drop imem_req at the same edge; any later ack SHALL be ignored.

Verification
REQ-035 Reset, fetch_start, ack 3 cycles later with rdata 32'h00500093 -> imem_addr=0, instr=32'h00500093, opcode=0010011, one fetch_done pulse.
REQ-036 pc=8, pc_load with pc_sel=01, branch_imm=-8 -> pc=0; pc_sel=00 from 32'hFFFFFFFC -> pc=0.
REQ-037 fetch_start, no ack for TIMEOUT cycles -> imem_req drops, fetch_err=1, instr unchanged; pc_reset -> fetch_err=0, pc=RESET_VECTOR.
REQ-038 pc_sel=10, branch_imm=32'h00000102 -> pc unchanged, fetch_err=1.
REQ-039 pc_load and pc_reset together with pc_sel=00 -> pc=RESET_VECTOR; pc_load during REQ -> pc unchanged.
REQ-040 reset asserted mid-REQ, ack next cycle -> imem_req=0, instr=32'h00000013, no fetch_done.
